phase_generator: RTL and testbench

Parametrised multi-phase, non-overlapping clock-phase generator. Divides `clk` into `PHASES` sequential time slots of programmable length and asserts exactly one phase output per slot, followed by a programmable dead time. Supports continuous and single-frame modes with graceful stop. Sits between the board clock and the phase-driven datapath that the controller top level feeds.

---
 rtl/phase_generator_if.sv | 36 +++
 rtl/phase_generator.sv | 128 ++++++++++++
 tb/tb_phase_generator.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/phase_generator_if.sv
// Handshake bundle between the phase generator and its controller.
// Carries frame_cnt only when PHASEGEN_FRAME_CNT_EN is defined.
interface phase_generator_if #(
   parameter int PHASES = 4,
   parameter int CNT_W  = 8
);
   localparam int IW = $clog2(PHASES);

   logic             enable;
   logic             single;
   logic [CNT_W-1:0] div;
   logic [CNT_W-1:0] gap;
   logic [PHASES-1:0] phase;
   logic [IW-1:0]    phase_idx;
   logic             frame_start;
   logic             busy;
`ifdef PHASEGEN_FRAME_CNT_EN
   logic [15:0]      frame_cnt;
`endif

   modport master (
      output enable, single, div, gap,
`ifdef PHASEGEN_FRAME_CNT_EN
      input  frame_cnt,
`endif
      input  phase, phase_idx, frame_start, busy
   );

   modport slave (
      input  enable, single, div, gap,
`ifdef PHASEGEN_FRAME_CNT_EN
      output frame_cnt,
`endif
      output phase, phase_idx, frame_start, busy
   );
endinterface

// File: rtl/phase_generator.sv
// Multi-phase non-overlapping clock-phase generator with dead time.
// Optional frame counter output enabled by PHASEGEN_FRAME_CNT_EN.
module phase_generator #(
   parameter int PHASES = 4,
   parameter int CNT_W  = 8
) (
   input logic              clk,
   input logic              rst,
   phase_generator_if.slave bus
);
   localparam int IW = $clog2(PHASES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LAST = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  div_s_q, div_s_d;
   logic [CNT_W-1:0]  gap_s_q, gap_s_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [PHASES-1:0] phase_q, phase_d;
   logic              fs_q, fs_d;
   logic              busy_q, busy_d;

   logic              slot_end;
   logic              frame_end;
   logic              act_ok;
   logic [CNT_W:0]    act_lim;

   assign slot_end  = (cnt_q == div_s_q);
   assign frame_end = slot_end && (idx_q == IW'(PHASES - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      div_s_d = div_s_q;
      gap_s_d = gap_s_q;
      unique case (state_q)
         IDLE: begin
            if (bus.enable) begin
               state_d = bus.single ? LAST : RUN;
               div_s_d = bus.div;
               gap_s_d = bus.gap;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         RUN, LAST: begin
            if (frame_end) begin
               cnt_d = '0;
               idx_d = '0;
               if (state_q == RUN && bus.enable) begin
                  div_s_d = bus.div;
                  gap_s_d = bus.gap;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (slot_end) begin
                  cnt_d = '0;
                  idx_d = idx_q + 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (state_q == RUN && !bus.enable) state_d = LAST;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs come from next-state values so they line up with state.
   assign act_ok  = {1'b0, gap_s_d} <= {1'b0, div_s_d};
   assign act_lim = {1'b0, div_s_d} - {1'b0, gap_s_d};

   always_comb begin
      busy_d = (state_d != IDLE);
      fs_d   = busy_d && (idx_d == '0) && (cnt_d == '0);
      for (int i = 0; i < PHASES; i++) begin
         phase_d[i] = busy_d && (idx_d == IW'(i)) && act_ok
                      && ({1'b0, cnt_d} <= act_lim);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         div_s_q <= '0;
         gap_s_q <= '0;
         phase_q <= '0;
         fs_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         div_s_q <= div_s_d;
         gap_s_q <= gap_s_d;
         phase_q <= phase_d;
         fs_q    <= fs_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.phase       = phase_q;
   assign bus.phase_idx   = idx_q;
   assign bus.frame_start = fs_q;
   assign bus.busy        = busy_q;

`ifdef PHASEGEN_FRAME_CNT_EN
   logic [15:0] fcnt_q, fcnt_d;

   assign fcnt_d = fcnt_q + 16'(fs_d);

   always_ff @(posedge clk) begin
      if (rst) fcnt_q <= '0;
      else     fcnt_q <= fcnt_d;
   end

   assign bus.frame_cnt = fcnt_q;
`endif
endmodule

// File: tb/tb_phase_generator.sv
// Scoreboard bench for phase_generator: a frame-time model pushes
// expected outputs per edge, popped and compared after the edge.
module tb_phase_generator;
   localparam int P  = 4;
   localparam int CW = 8;
   localparam int IW = $clog2(P);

   typedef struct packed {
      logic [P-1:0]  ph;
      logic [IW-1:0] idx;
      logic          fs;
      logic          busy;
      logic [15:0]   fc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_err = 0;
   exp_t sbq[$];

   bit   m_on, m_last;
   int   m_t, m_div, m_gap, m_fc;

   phase_generator_if #(.PHASES(P), .CNT_W(CW)) bus ();

   phase_generator #(.PHASES(P), .CNT_W(CW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Frame-time model: position m_t within a frame of P*(div+1) cycles.
   task automatic model_edge(output exp_t e);
      int per, slot, c;
      if (rst) begin
         m_on = 0; m_last = 0; m_t = 0;
         m_div = 0; m_gap = 0; m_fc = 0;
      end else if (!m_on) begin
         if (bus.enable) begin
            m_on = 1; m_last = bus.single; m_t = 0;
            m_div = int'(bus.div); m_gap = int'(bus.gap);
         end
      end else begin
         per = P * (m_div + 1);
         if (m_t == per - 1) begin
            m_t = 0;
            if (!m_last && bus.enable) begin
               m_div = int'(bus.div); m_gap = int'(bus.gap);
            end else begin
               m_on = 0; m_last = 0;
            end
         end else begin
            m_t++;
            if (!bus.enable) m_last = 1;
         end
      end
      e = '0;
      if (m_on) begin
         slot  = m_t / (m_div + 1);
         c     = m_t % (m_div + 1);
         e.busy = 1'b1;
         e.idx  = IW'(slot);
         e.fs   = (m_t == 0);
         if (m_gap <= m_div && c <= m_div - m_gap) e.ph = P'(1) << slot;
         if (e.fs && !rst) m_fc = (m_fc + 1) & 16'hffff;
      end
      e.fc = 16'(m_fc);
   endtask

   task automatic step();
      exp_t e, g;
      model_edge(e);
      sbq.push_back(e);
      @(posedge clk);
      #1;
      g = sbq.pop_front();
      chk("phase", 32'(bus.phase), 32'(g.ph));
      chk("phase_idx", 32'(bus.phase_idx), 32'(g.idx));
      chk("frame_start", 32'(bus.frame_start), 32'(g.fs));
      chk("busy", 32'(bus.busy), 32'(g.busy));
      chk("onehot", 32'($countones(bus.phase) <= 1), 32'd1);
`ifdef PHASEGEN_FRAME_CNT_EN
      chk("frame_cnt", 32'(bus.frame_cnt), 32'(g.fc));
`endif
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int nb;
      bit hit;
      rst = 1'b1;
      bus.enable = 1'b0; bus.single = 1'b0;
      bus.div = '0; bus.gap = '0;
      #1;
      run(3);
      rst = 1'b0;
      run(2);

      // continuous run, 3 active + 1 dead per slot
      bus.div = 8'd3; bus.gap = 8'd1; bus.enable = 1'b1;
      run(40);

      // reset mid-frame at idx=2 cnt=1
      hit = 0;
      for (int i = 0; i < 64 && !hit; i++) begin
         step();
         hit = (m_t == 9);
      end
      chk("mid_reach", 32'(hit), 32'd1);
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      run(6);

      // walking one-hot
      bus.enable = 1'b0;
      run(20);
      bus.div = 8'd0; bus.gap = 8'd0; bus.enable = 1'b1;
      run(12);
      bus.enable = 1'b0;
      run(6);

      // single frame, drop enable after start
      bus.single = 1'b1; bus.div = 8'd1; bus.gap = 8'd0;
      bus.enable = 1'b1;
      nb = 0;
      step();
      if (bus.busy) nb++;
      bus.enable = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.busy) nb++;
      end
      chk("single_busy", 32'(nb), 32'd8);
      bus.enable = 1'b1;
      run(20);
      bus.enable = 1'b0; bus.single = 1'b0;
      run(12);

      // graceful stop at idx=1 with div change mid-frame
      bus.div = 8'd3; bus.gap = 8'd1; bus.enable = 1'b1;
      run(5);
      bus.enable = 1'b0; bus.div = 8'd7;
      run(16);
      bus.enable = 1'b1;
      run(40);
      bus.enable = 1'b0;
      run(40);

      // dead slot
      bus.div = 8'd3; bus.gap = 8'd5; bus.enable = 1'b1;
      run(20);
      bus.enable = 1'b0;
      run(20);

      // maximum slot length
      bus.div = 8'd255; bus.gap = 8'd0; bus.enable = 1'b1;
      run(1030);
      bus.gap = 8'd255; bus.enable = 1'b0;
      run(1030);
      bus.enable = 1'b1;
      run(300);
      bus.enable = 1'b0;
      run(1030);

      // random mix
      for (int i = 0; i < 400; i++) begin
         bus.enable = ($urandom_range(0, 3) != 0);
         bus.single = ($urandom_range(0, 7) == 0);
         bus.div    = CW'($urandom_range(0, 4));
         bus.gap    = CW'($urandom_range(0, 4));
         rst        = ($urandom_range(0, 63) == 0);
         step();
      end
      rst = 1'b0;
      bus.enable = 1'b0;
      run(30);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
